// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Reset and lock manager sitting between the board reference clock and the
// clock-generation PLL. Pulses the PLL reset, waits for a synchronized lock
// indication, requires lock to stay stable for a programmable time and only
// then releases the downstream system reset. Lock loss, a lock-acquisition
// timeout or a software request re-runs the sequence. Two saturating event
// counters are exposed for bring-up diagnostics.
//
// Ports:
//   clock_in        in   reference clock (free-running)
//   reset_in        in   asynchronous, active-low reset
//   pll_locked      in   PLL lock indication, asynchronous to clock_in
//   soft_reset_req  in   single-cycle synchronous request to restart
//   pll_rst         out  active-high reset to the PLL
//   sys_reset_n     out  active-low system reset to downstream domains
//   ready           out  high while the system is released
//   lock_lost_count out  saturating count of lock losses while running
//   retry_count     out  saturating count of lock-acquisition timeouts
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [7:0] lock_lost_count,
  output logic [7:0] retry_count
);

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABILIZE = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   w_lost_inc;
  logic                   w_retry_inc;
  logic                   r_pll_rst;
  logic                   r_sys_reset_n;
  logic                   r_ready;
  logic [7:0]             r_lock_lost;
  logic [7:0]             r_retry;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lock synchronizer: the FSM only ever looks at the last stage.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next-state decode. Lock loss in RUN is evaluated ahead of the software
  // request so that a coincident request still records the loss.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_lost_inc  = 1'b0;
    w_retry_inc = 1'b0;

    if (r_state == S_RUN && !w_lock_s) begin
      w_state_nxt = S_PLL_RESET;
      w_lost_inc  = 1'b1;
    end else if (soft_reset_req) begin
      w_state_nxt = S_PLL_RESET;
    end else begin
      case (r_state)
        S_PLL_RESET: begin
          if (r_cnt == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = S_STABILIZE;
          end else if (r_cnt == C_TIMEOUT_LAST) begin
            w_state_nxt = S_PLL_RESET;
            w_retry_inc = 1'b1;
          end
        end
        S_STABILIZE: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
          end else if (r_cnt == C_STABLE_LAST) begin
            w_state_nxt = S_RUN;
          end
        end
        default: begin
          w_cnt_nxt = r_cnt;
        end
      endcase
    end

    // Any state change, or a restart of the pulse, begins a fresh count.
    if (w_state_nxt != r_state || soft_reset_req) begin
      w_cnt_nxt = '0;
    end
  end

  // State, counter and registered outputs all load from the same decode so
  // the outputs are glitch-free and move on the same edge as the state.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state       <= S_PLL_RESET;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_lock_lost   <= '0;
      r_retry       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pll_rst     <= (w_state_nxt == S_PLL_RESET);
      r_sys_reset_n <= (w_state_nxt == S_RUN);
      r_ready       <= (w_state_nxt == S_RUN);
      if (w_lost_inc)  r_lock_lost <= sat_inc8(r_lock_lost);
      if (w_retry_inc) r_retry     <= sat_inc8(r_retry);
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign lock_lost_count = r_lock_lost;
  assign retry_count     = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Self-checking bench for pll_reset_sequencer with small parameters. A
// behavioural model (delay line for the synchronizer plus a phase/elapsed
// description of the sequence) predicts every output after every edge;
// directed scenarios additionally measure pulse widths and latencies.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int R  = 4;
  localparam int N  = 8;
  localparam int T  = 32;
  localparam int S  = 2;
  localparam int CW = 6;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic [7:0] lock_lost_count;
  logic [7:0] retry_count;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (N),
    .PLL_RST_CYCLES     (R),
    .LOCK_TIMEOUT_CYCLES(T),
    .CNT_W              (CW),
    .SYNC_STAGES        (S)
  ) dut (
    .clock_in       (clock_in),
    .reset_in       (reset_in),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .lock_lost_count(lock_lost_count),
    .retry_count    (retry_count)
  );

  always #10 clock_in = ~clock_in;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural model. Phases: 0 reset pulse, 1 waiting for lock,
  // 2 proving lock stable, 3 released. 'elapsed' = cycles spent counting
  // toward the current phase's goal.
  int m_phase, m_el, m_lost, m_retry;
  bit m_dl[S];

  function automatic void m_reset();
    m_phase = 0; m_el = 0; m_lost = 0; m_retry = 0;
    for (int i = 0; i < S; i++) m_dl[i] = 1'b0;
  endfunction

  function automatic void m_enter(input int ph);
    m_phase = ph;
    m_el    = 0;
  endfunction

  function automatic void m_step(input bit lk, input bit rq);
    bit ls;
    ls = m_dl[S-1];
    for (int i = S - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = lk;
    if (m_phase == 3 && !ls) begin
      if (m_lost < 255) m_lost++;
      m_enter(0);
    end else if (rq) begin
      m_enter(0);
    end else if (m_phase == 0) begin
      m_el++;
      if (m_el == R) m_enter(1);
    end else if (m_phase == 1) begin
      if (ls) m_enter(2);
      else begin
        m_el++;
        if (m_el == T) begin
          if (m_retry < 255) m_retry++;
          m_enter(0);
        end
      end
    end else if (m_phase == 2) begin
      if (!ls) m_enter(1);
      else begin
        m_el++;
        if (m_el == N) m_enter(3);
      end
    end
  endfunction

  function automatic logic [18:0] dut_vec();
    return {pll_rst, sys_reset_n, ready, lock_lost_count, retry_count};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_phase == 0, m_phase == 3, m_phase == 3, 8'(m_lost), 8'(m_retry)};
  endfunction

  task automatic cyc(input bit lk, input bit rq);
    pll_locked     = lk;
    soft_reset_req = rq;
    @(posedge clock_in);
    m_step(lk, rq);
    #1;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
    soft_reset_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    #1;
    m_reset();
    check("async_reset", 32'(dut_vec()), 32'h40000);
    @(negedge clock_in);
    reset_in = 1'b1;
  endtask

  // Cycles with lock high until release; returns edges after the first
  // sampled-high edge.
  task automatic measure_release(output int lat);
    int e;
    e = 0;
    do begin cyc(1'b1, 1'b0); e++; end while (!sys_reset_n && e < 200);
    lat = e - 1;
  endtask

  // Counts cycles that pll_rst stays high, starting with it already high.
  task automatic measure_pulse(output int w);
    int k;
    w = 1; k = 0;
    do begin cyc(1'b0, 1'b0); if (pll_rst) w++; k++; end while (pll_rst && k < 100);
  endtask

  initial begin
    int e, w, lat, remaining;
    bit lk;

    // Power-up
    do_reset();
    e = 0;
    do begin cyc(1'b0, 1'b0); e++; end while (pll_rst && e < 50);
    check("pwrup_pulse_edges", e, R);
    repeat (6) cyc(1'b0, 1'b0);
    measure_release(lat);
    check("pwrup_release_lat", lat, S + N);
    check("pwrup_ready", ready, 1);
    check("pwrup_lost", lock_lost_count, 0);

    // Lock loss in RUN
    repeat (5) cyc(1'b1, 1'b0);
    e = 0;
    do begin cyc(1'b0, 1'b0); e++; end while (sys_reset_n && e < 50);
    check("loss_latency", e - 1, S);
    check("loss_pll_rst", pll_rst, 1);
    measure_pulse(w);
    check("loss_pulse_width", w, R);
    check("loss_count", lock_lost_count, 1);
    repeat (3) cyc(1'b0, 1'b0);
    measure_release(lat);
    check("relock_release_lat", lat, S + N);

    // Soft reset coinciding with lock loss seen in RUN
    repeat (4) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("soft_pre_run", sys_reset_n, 1);
    cyc(1'b0, 1'b1);
    check("soft_pll_rst", pll_rst, 1);
    measure_pulse(w);
    check("soft_pulse_width", w, R);
    check("soft_lost_count", lock_lost_count, 2);

    // Soft reset alone restarts the pulse, no counter change
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    measure_pulse(w);
    check("soft_restart_width", w, R);
    check("soft_restart_lost", lock_lost_count, 2);

    // Timeout and saturation
    do_reset();
    e = 0;
    do begin cyc(1'b0, 1'b0); e++; end while (retry_count == 0 && e < 200);
    check("timeout_first", e, R + T);
    check("timeout_pll_rst", pll_rst, 1);
    e = 0;
    do begin cyc(1'b0, 1'b0); e++; end while (retry_count == 1 && e < 200);
    check("timeout_period", e, R + T);
    check("timeout_retry2", retry_count, 2);
    e = 0;
    while (retry_count != 8'd255 && e < 12000) begin cyc(1'b0, 1'b0); e++; end
    repeat (100) cyc(1'b0, 1'b0);
    check("retry_saturate", retry_count, 255);

    // Reset asserted mid-STABILIZE
    e = 0;
    while (pll_rst && e < 50) begin cyc(1'b0, 1'b0); e++; end
    repeat (5) cyc(1'b1, 1'b0);
    check("stab_not_released", sys_reset_n, 0);
    pll_locked = 1'b0;
    do_reset();
    check("mid_reset_retry", retry_count, 0);
    repeat (R + 2) cyc(1'b0, 1'b0);
    measure_release(lat);
    check("post_reset_release", lat, S + N);

    // Lock glitch in STABILIZE
    do_reset();
    repeat (R) cyc(1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    measure_release(lat);
    check("glitch_release_lat", lat, S + N);
    check("glitch_lost", lock_lost_count, 0);

    // Randomized traffic against the model
    lk = 1'b0; remaining = 0;
    repeat (4000) begin
      if (remaining == 0) begin
        lk = ~lk;
        remaining = lk ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 60));
      end
      remaining--;
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc(lk, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock manager between the board reference clock and the clock-generation PLL. Runs on the reference clock. Drives the PLL reset input, synchronizes and qualifies the PLL lock indication, and releases a system reset to the downstream clock domains only after lock has been stable for a programmable time. Loss of lock, lock-acquisition timeout and software requests re-run the sequence. Event counters are exposed for bring-up diagnostics.

## Interface
- LOCK_STABLE_CYCLES, 1024: continuous synchronized-lock cycles required before reset release (≥1)
- PLL_RST_CYCLES, 16: width of the PLL reset pulse in clocks (≥1)
- LOCK_TIMEOUT_CYCLES, 65536: clocks spent waiting for lock before the PLL is reset again (≥1)
- CNT_W, 17: shared down/up counter width; must hold max(all three above) − 1
- SYNC_STAGES, 2: flop depth of the pll_locked synchronizer (≥2)
- clock_in  in  1  reference clock (50 MHz board clock, free-running)
- reset_in  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock indication, asynchronous to clock_in
- soft_reset_req  in  1  single-cycle synchronous request to re-run the sequence
- pll_rst  out  1  active-high reset to the PLL
- sys_reset_n  out  1  active-low system reset to downstream domains (re-synchronized per domain downstream)
- ready  out  1  high while the system is released
- lock_lost_count  out  8  saturating count of lock losses while in RUN
- retry_count  out  8  saturating count of lock-acquisition timeouts

## Operation
- lock_s = pll_locked after SYNC_STAGES flops; the FSM uses lock_s only.
- States: PLL_RESET, WAIT_LOCK, STABILIZE, RUN. Counter cnt is cleared on every state change.
- PLL_RESET: pll_rst=1. cnt increments each cycle. When cnt==PLL_RST_CYCLES−1, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0. If lock_s=1, go to STABILIZE. Otherwise cnt increments. When cnt==LOCK_TIMEOUT_CYCLES−1 with lock_s=0, go to PLL_RESET and increment retry_count (saturates at 255).
- STABILIZE: if lock_s=0, go to WAIT_LOCK; no counters change. Otherwise, when cnt==LOCK_STABLE_CYCLES−1, go to RUN; else cnt increments.
- RUN: sys_reset_n=1 and ready=1. If lock_s=0, go to PLL_RESET and increment lock_lost_count (saturates at 255).
- soft_reset_req=1 in any state forces PLL_RESET with cnt cleared. This restarts the pulse if already in PLL_RESET. No counter changes.
- If soft_reset_req and lock loss occur in the same RUN cycle, the state goes to PLL_RESET and lock_lost_count still increments.
- Outputs are dedicated flops loaded with the same next-state decode as the state register. They are glitch-free and change on the same edge as the state.
- Only the reset_in path resets counter values; no sequence event clears lock_lost_count or retry_count.

## Timing
- Reset values (asynchronous, immediate on reset_in=0): state=PLL_RESET, cnt=0, synchronizer=0, pll_rst=1, sys_reset_n=0, ready=0, lock_lost_count=0, retry_count=0.
- After reset_in deasserts, pll_rst stays high for exactly PLL_RST_CYCLES rising edges.
- Release latency: pll_locked first sampled high at edge E0 (with state=WAIT_LOCK) gives sys_reset_n=1 and ready=1 from edge E0+SYNC_STAGES+LOCK_STABLE_CYCLES, provided lock stays high throughout.
- Loss latency: pll_locked sampled low at E0 while in RUN gives sys_reset_n=0, ready=0 and pll_rst=1 from edge E0+SYNC_STAGES.
- soft_reset_req high at edge E gives the PLL_RESET outputs from edge E.
- Timeout: WAIT_LOCK entered at edge W with lock_s constantly 0 gives pll_rst=1 from edge W+LOCK_TIMEOUT_CYCLES.
- Reset mid-sequence from any state returns all outputs to reset values without waiting for a clock.

## Test plan
Parameters for all scenarios: R=4, N=8, T=32, S=2.
- Power-up: release reset_in, then raise pll_locked 10 cycles later. Required: pll_rst high for 4 edges; sys_reset_n rises exactly 10 edges after lock is first sampled; ready follows.
- Lock glitch in STABILIZE: drop pll_locked for 1 cycle at stabilize count 5. Required: state returns to WAIT_LOCK; release occurs 10 edges after lock returns; lock_lost_count=0.
- Timeout: hold pll_locked=0. Required: pll_rst re-pulses every 36 cycles; retry_count increments 1, 2, 3, … and saturates at 255 after 255 timeouts.
- Lock loss in RUN: drop pll_locked. Required: sys_reset_n=0 two edges later; pll_rst high 4 cycles; lock_lost_count=1; re-release after relock.
- soft_reset_req coinciding with a lock drop in RUN: required: single PLL_RESET entry; lock_lost_count increments by exactly 1; pulse width 4.
- Assert reset_in mid-STABILIZE: required: immediate pll_rst=1, sys_reset_n=0, both counters 0; normal sequence on release.
